// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// State and owner encodings used by the arbiter and its response tracker.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_resp_tracker.sv
// Tracks the single in-flight memory access: latency countdown,
// owning port and whether it was a store.
module mem_resp_tracker
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic launch_i,
  input  logic launch_d_i,
  input  logic launch_we_i,
  output logic rvalid_o,
  output logic owner_d_o,
  output logic store_o
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] lat_cnt_q, lat_cnt_d;
  arb_owner_t    owner_q;
  logic          store_q;

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if (launch_i)
      lat_cnt_d = CW'(MEM_LATENCY);
    else if (lat_cnt_q != '0)
      lat_cnt_d = lat_cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt_q <= '0;
      owner_q   <= OWN_IF;
      store_q   <= 1'b0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      if (launch_i) begin
        owner_q <= launch_d_i ? OWN_D : OWN_IF;
        store_q <= launch_d_i & launch_we_i;
      end
    end
  end

  assign rvalid_o  = (lat_cnt_q == CW'(1));
  assign owner_d_o = (owner_q == OWN_D);
  assign store_o   = store_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and
// load/store; data wins ties until its burst budget runs out.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);

  arb_state_t    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rsp, rsp_d_own, rsp_store;
  logic          grant_ok, d_win, if_win, launch;

  // The response cycle frees the memory, so a new grant may overlap it.
  assign grant_ok = !reset && (state_q == ARB_IDLE || rsp);
  assign d_win    = grant_ok && d_req &&
                    (!if_req || burst_q != BW'(MAX_DATA_BURST));
  assign if_win   = grant_ok && if_req && !d_win;
  assign launch   = d_win || if_win;
  assign d_gnt    = d_win;
  assign if_gnt   = if_win;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    unique case (1'b1)
      d_win: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end
      if_win: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
        mem_be   = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (launch)
      state_d = ARB_BUSY;
    else if (rsp)
      state_d = ARB_IDLE;
    burst_d = burst_q;
    if (d_win) begin
      if (!if_req)
        burst_d = '0;
      else if (burst_q != BW'(MAX_DATA_BURST))
        burst_d = burst_q + BW'(1);
    end else if (if_win) begin
      burst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  mem_resp_tracker #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .launch_i    (launch),
    .launch_d_i  (d_win),
    .launch_we_i (d_we),
    .rvalid_o    (rsp),
    .owner_d_o   (rsp_d_own),
    .store_o     (rsp_store)
  );

  assign if_rvalid = !reset && rsp && !rsp_d_own;
  assign d_rvalid  = !reset && rsp && rsp_d_own;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !rsp_store) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at MEM_LATENCY 2 and 1, driven by
// random traffic against a cycle-budget reference model.
module tb_mem_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit done [2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] w,
                                        logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h100 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 2 : 1;

    logic        reset, if_req, if_gnt, if_rvalid;
    logic        d_req, d_we, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  d_be, mem_be;

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .MEM_LATENCY(LAT), .MAX_DATA_BURST(4)
    ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_be(d_be), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // Memory device: answers what the DUT actually issued.
    logic [31:0] dev_mem [bit [31:0]];
    logic [31:0] pipe [8];
    bit          pend [8];
    int          cyc = 0;
    bit          iss = 0;
    logic        iss_we;
    logic [31:0] iss_a, iss_wd, old;
    logic [3:0]  iss_be;

    always @(posedge clk) begin
      if (iss) begin
        old = dev_mem.exists(iss_a) ? dev_mem[iss_a] : init_word(iss_a);
        if (iss_we) dev_mem[iss_a] = merge(old, iss_wd, iss_be);
        pipe[(cyc + LAT) % 8] = old;
        pend[(cyc + LAT) % 8] = 1;
      end
      cyc++;
      mem_rdata = pend[cyc % 8] ? pipe[cyc % 8] : $urandom;
      pend[cyc % 8] = 0;
    end

    // Reference model: one access per LAT cycles, responses in order.
    logic [31:0] ref_mem [bit [31:0]];
    exp_t        q [$];
    exp_t        e;
    int          next_ok = 0;
    int          streak = 0;
    bit          ok, ed, ei, evi, evd;
    logic        ewe;
    logic [31:0] ea, ewd, rd, edata;
    logic [3:0]  ebe;

    always @(negedge clk) begin
      iss = 0;
      if (reset) begin
        chk("rst_ctrl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid,
                             mem_req, mem_we}), 32'h0);
        chk("rst_data", if_rdata | d_rdata | mem_addr | mem_wdata |
                        32'(mem_be), 32'h0);
        q.delete();
        streak  = 0;
        next_ok = cyc + 1;
      end else begin
        evi = 0; evd = 0; edata = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          evd = e.is_d; evi = !e.is_d; edata = e.data;
        end
        chk("if_rvalid", 32'(if_rvalid), 32'(evi));
        chk("d_rvalid", 32'(d_rvalid), 32'(evd));
        chk("if_rdata", if_rdata, evi ? edata : 32'h0);
        chk("d_rdata", d_rdata, evd ? edata : 32'h0);

        ok = cyc >= next_ok;
        ed = ok && d_req && (!if_req || streak < 4);
        ei = ok && if_req && !ed;
        chk("if_gnt", 32'(if_gnt), 32'(ei));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        ewe = 0; ea = 0; ewd = 0; ebe = 0;
        if (ed || ei) begin
          ea  = ed ? d_addr : if_addr;
          ewe = ed && d_we;
          ewd = ed ? d_wdata : 32'h0;
          ebe = ed ? d_be : 4'hF;
          rd  = ref_mem.exists(ea) ? ref_mem[ea] : init_word(ea);
          if (ewe) ref_mem[ea] = merge(rd, ewd, ebe);
          q.push_back('{is_d: ed, data: ewe ? 32'h0 : rd, due: cyc + LAT});
          streak  = (ed && if_req) ? ((streak < 4) ? streak + 1 : 4) : 0;
          next_ok = cyc + LAT;
        end
        chk("mem_req", 32'(mem_req), 32'(ed || ei));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_be", 32'(mem_be), 32'(ebe));
        if (mem_req) begin
          iss = 1; iss_we = mem_we; iss_a = mem_addr;
          iss_wd = mem_wdata; iss_be = mem_be;
        end
      end
    end

    // Stimulus: requests change only once granted.
    bit gi, gd;

    task automatic step(int mode);
      @(negedge clk);
      gi = if_gnt;
      gd = d_gnt;
      @(posedge clk);
      #1;
      if (!if_req || gi) begin
        if_req  = (mode == 1) ? 1'b1 :
                  (mode == 2) ? 1'b0 : ($urandom % 3 != 0);
        if_addr = rnd_addr();
      end
      if (!d_req || gd) begin
        d_req   = (mode == 1) ? 1'b1 :
                  (mode == 2) ? 1'b0 : ($urandom % 2 == 0);
        d_we    = 1'($urandom);
        d_addr  = rnd_addr();
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
    endtask

    initial begin
      bit found;
      reset = 1; if_req = 0; d_req = 0; d_we = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      for (int i = 0; i < 300; i++) step(0);
      for (int i = 0; i < 40; i++) step(1);
      for (int k = 0; k < 3; k++) begin
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
          step(0);
          found = gi || gd;
        end
        chk("rst_grant_wait", 32'(found), 32'h1);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
      end
      for (int i = 0; i < 200; i++) step(0);
      for (int i = 0; i < 30; i++) step(2);
      chk("drain_empty", 32'(q.size()), 32'h0);
      done[g] = 1;
    end
  end

  initial begin
    for (int i = 0; i < 5000 && !(done[0] && done[1]); i++)
      @(posedge clk);
    chk("finish_in_budget", 32'(done[0] && done[1]), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
